// File: rtl/queue_param.sv
// -----------------------------------------------------------------------------
// queue_param
//   Parametrised single-clock FIFO. Buffers data between a producer and a
//   consumer that share one clock. Holds a true DEPTH entries: occupancy is
//   tracked in its own counter rather than inferred from the pointers. Read
//   data is registered and comes with a one-cycle valid strobe. Rejected
//   writes and reads raise sticky error flags until they are cleared.
//
// Parameters
//   DATA_W     data width in bits (>=1)
//   DEPTH      number of entries, power of 2, >=2
//   AF_THRESH  almost_full when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//   CNT_W      occupancy width, derived from DEPTH (do not override)
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset (0 = reset)
//   din           in   write data
//   write         in   write request
//   read          in   read request
//   clr_err       in   synchronous clear of overflow/underflow
//   dout          out  registered read data, holds between reads
//   dout_valid    out  1-cycle strobe, dout was updated this cycle
//   empty         out  count == 0
//   full          out  count == DEPTH
//   almost_empty  out  count <= AE_THRESH
//   almost_full   out  count >= AF_THRESH
//   count         out  current occupancy, 0..DEPTH
//   overflow      out  sticky, a write was rejected
//   underflow     out  sticky, a read was rejected
// -----------------------------------------------------------------------------
module queue_param #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              write,
    input  logic              read,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    // Thresholds sized to the counter so every compare is width-matched.
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Storage is deliberately not reset; the pointers and count define
    // which entries are meaningful.
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              empty_s;
    logic              full_s;
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic              wr_err_s;
    logic              rd_err_s;
    logic [CNT_W-1:0]  count_nxt_s;

    // Status decode straight off the registered count, so flags track count
    // in the same cycle.
    always_comb begin
        empty_s = (count_r == ZERO_C);
        full_s  = (count_r == DEPTH_C);
    end

    // Request qualification. A write into a full FIFO is still accepted when
    // a read frees a slot in the same cycle; a read from an empty FIFO is
    // never accepted, even if a write lands in that cycle.
    always_comb begin
        rd_ok_s  = read & ~empty_s;
        wr_ok_s  = write & (~full_s | rd_ok_s);
        wr_err_s = write & ~wr_ok_s;
        rd_err_s = read & ~rd_ok_s;
    end

    // Next occupancy: a simultaneous accepted read and write leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Write port into the storage array; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[head_r] <= din;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= ZERO_C;
        end else begin
            if (wr_ok_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            if (rd_ok_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // Registered read data with its one-cycle valid strobe; dout holds
    // its last value when no read is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r       <= {DATA_W{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            if (rd_ok_s) begin
                dout_r       <= mem_r[tail_r];
                dout_valid_r <= 1'b1;
            end else begin
                dout_r       <= dout_r;
                dout_valid_r <= 1'b0;
            end
        end
    end

    // Sticky error flags. A fresh error takes priority over clr_err so an
    // error landing in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_err_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (rd_err_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign dout         = dout_r;
    assign dout_valid   = dout_valid_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_r <= AE_C);
    assign almost_full  = (count_r >= AF_C);

endmodule

// File: tb/tb_queue_param.sv
// -----------------------------------------------------------------------------
// tb_queue_param
//   Directed, table-driven bench for queue_param (DATA_W=16, DEPTH=8, AF=6,
//   AE=2). Each record holds the inputs for one clock and the outputs expected
//   just after that edge. Reset and asynchronous mid-stream reset are
//   hand-written sequences.
// -----------------------------------------------------------------------------
module tb_queue_param;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        clr;
        logic [15:0] din;
        logic [15:0] e_dout;
        logic        e_dv;
        logic [3:0]  e_cnt;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        empty;
    logic        full;
    logic        almost_empty;
    logic        almost_full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    // Expected {empty, full, almost_empty, almost_full} for each count 0..8.
    logic [3:0] flag_tab [0:8] = '{4'b1010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                   4'b0000, 4'b0001, 4'b0001, 4'b0101};

    vec_t vecs[$];

    always #5 clk = ~clk;

    queue_param #(
        .DATA_W(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .write(write), .read(read),
        .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    function automatic vec_t mk(input logic wr, input logic rd, input logic clr,
                                input logic [15:0] d, input logic [15:0] e_dout,
                                input logic e_dv, input logic [3:0] e_cnt,
                                input logic e_ovf, input logic e_udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = d;
        v.e_dout = e_dout; v.e_dv = e_dv; v.e_cnt = e_cnt;
        v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    task automatic check(input string name, input vec_t v);
        logic [26:0] act;
        logic [26:0] exp;
        act = {dout, dout_valid, count, empty, full, almost_empty, almost_full,
               overflow, underflow};
        exp = {v.e_dout, v.e_dv, v.e_cnt, flag_tab[v.e_cnt], v.e_ovf, v.e_udf};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got dout=%h dv=%b cnt=%0d e/f/ae/af=%b ovf=%b udf=%b, want dout=%h dv=%b cnt=%0d e/f/ae/af=%b ovf=%b udf=%b",
                     name, dout, dout_valid, count,
                     {empty, full, almost_empty, almost_full}, overflow, underflow,
                     v.e_dout, v.e_dv, v.e_cnt, flag_tab[v.e_cnt], v.e_ovf, v.e_udf);
        end
    endtask

    // Drive one record on the falling edge, sample 1 ns after the rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        write = v.wr; read = v.rd; clr_err = v.clr; din = v.din;
        @(posedge clk);
        #1;
        check(name, v);
        write = 1'b0; read = 1'b0; clr_err = 1'b0; din = 16'h0000;
    endtask

    initial begin
        logic [15:0] last;

        // ---- Table: fill / overflow ----
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'(16'h1000 + i), 16'h0000, 1'b0, 4'(i + 1), 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'hDEAD, 16'h0000, 1'b0, 4'd8, 1'b1, 1'b0));
        // new error in clearing cycle wins
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 16'hDEAD, 16'h0000, 1'b0, 4'd8, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 4'd8, 1'b0, 1'b0));
        // ---- drain / underflow ----
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'(16'h1000 + i), 1'b1, 4'(7 - i), 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1007, 1'b0, 4'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1007, 1'b0, 4'd0, 1'b0, 1'b0));
        // ---- read+write while empty ----
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0042, 16'h1007, 1'b0, 4'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0042, 1'b1, 4'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0042, 1'b0, 4'd0, 1'b0, 1'b0));
        // ---- wrap: write 5 / read 5, three rounds ----
        last = 16'h0042;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++)
                vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'(16'h2000 + 5 * r + i), last, 1'b0, 4'(i + 1), 1'b0, 1'b0));
            for (int i = 0; i < 5; i++)
                vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'(16'h2000 + 5 * r + i), 1'b1, 4'(4 - i), 1'b0, 1'b0));
            last = 16'(16'h2000 + 5 * r + 4);
        end
        // ---- read+write while full ----
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'(16'h3000 + i), last, 1'b0, 4'(i + 1), 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h3000, 1'b1, 4'd8, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'(16'h3001 + i), 1'b1, 4'(7 - i), 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 4'd0, 1'b0, 1'b0));
        // ---- partial fill before async reset: 5 writes, 1 read -> count 4 ----
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'(16'h4000 + i), 16'hBEEF, 1'b0, 4'(i + 1), 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h4000, 1'b1, 4'd4, 1'b0, 1'b0));

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < vecs.size(); k++)
            apply(vecs[k], $sformatf("vec%0d", k));

        // ---- Async reset mid-stream, asserted away from the clock edge ----
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        reset = 1'b1;
        apply(mk(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0), "clr_no_err");
        apply(mk(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1), "udf_wins_clr");
        apply(mk(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0), "clr_udf");
        apply(mk(1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000, 1'b0, 4'd1, 1'b0, 1'b0), "post_rst_wr");
        apply(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h5555, 1'b1, 4'd0, 1'b0, 1'b0), "post_rst_rd");
        apply(mk(1'b1, 1'b0, 1'b0, 16'h6666, 16'h5555, 1'b0, 4'd1, 1'b0, 1'b0), "mid_wr");
        apply(mk(1'b1, 1'b1, 1'b0, 16'h7777, 16'h6666, 1'b1, 4'd1, 1'b0, 1'b0), "mid_rw");
        apply(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h7777, 1'b1, 4'd0, 1'b0, 1'b0), "mid_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
